core_result_packer: RTL and testbench

Receive-side counterpart of the HPU core's result outputs. Captures each `store` pulse's `DIM+1`-bit hypervector into a small vector FIFO and serialises it, LSB slice first, onto an `OUT_W`-bit valid/ready stream toward the DMA/box writer. The core's `last` pulse becomes a `put_last` flag on the final beat of the job. Sits between one core and the output stream mux.

---
 rtl/core_result_packer.sv | 145 ++++++++++++++
 tb/tb_core_result_packer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_result_packer.sv
// Buffers HPU core result vectors in a small FIFO and streams them out OUT_W bits per beat,
// LSB slice first. Define PACKER_OVF_EN to build the sticky overflow flag.
module core_result_packer #(
  parameter int unsigned DIM   = 1023,
  parameter int unsigned OUT_W = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             store,
  input  logic [DIM:0]     core_result,
  input  logic             last,
  output logic             put_v,
  output logic [OUT_W-1:0] put_d,
  output logic             put_last,
  input  logic             put_ready,
  output logic             overflow
);

  localparam int unsigned BEATS = (DIM + 1) / OUT_W;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);
  localparam logic [AW:0]   DepthC   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   OneC     = (AW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StSend, StFlush} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            pend_last_q, pend_last_d;
  logic            stall_q, hold_last_q;
  logic [DIM:0]    mem [DEPTH];

  logic [BEATS-1:0][OUT_W-1:0] head;
  logic store_en, hs, final_beat, pop, push;

  assign store_en   = run & store;
  assign head       = mem[rptr_q];
  assign hs         = put_v & put_ready;
  assign final_beat = (beat_q == LastBeat);
  assign pop        = hs & (state_q == StSend) & final_beat;
  // The head's final beat leaving frees a slot in the same cycle.
  assign push       = store_en & ((count_q != DepthC) | pop);

  // FIFO and serialiser next-state
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    beat_d      = beat_q;
    pend_last_d = pend_last_q;
    count_d     = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (hs && (state_q == StSend)) beat_d = final_beat ? '0 : beat_q + 1'b1;
    if (hs && put_last) pend_last_d = 1'b0;
    if (run && last)    pend_last_d = 1'b1;
    if (!run) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      beat_d      = '0;
      pend_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      beat_q      <= '0;
      pend_last_q <= 1'b0;
      stall_q     <= 1'b0;
      hold_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      beat_q      <= beat_d;
      pend_last_q <= pend_last_d;
      stall_q     <= run & put_v & ~put_ready;
      hold_last_q <= run & put_last;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= core_result;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (count_d != '0)    state_d = StSend;
        else if (pend_last_d) state_d = StFlush;
      end
      StSend: begin
        if (pop && (put_last || (count_d == '0))) state_d = StIdle;
      end
      StFlush: begin
        if (hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (!run) state_d = StIdle;
  end

  always_comb begin
    put_v    = 1'b0;
    put_d    = '0;
    put_last = 1'b0;
    case (state_q)
      StSend: begin
        put_v    = 1'b1;
        put_d    = head[beat_q];
        // Freeze the flag while stalled so a late push or last cannot change an offered beat.
        put_last = stall_q ? hold_last_q
                           : (final_beat & (count_q == OneC) & ~push & pend_last_q);
      end
      StFlush: begin
        put_v    = 1'b1;
        put_last = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PACKER_OVF_EN
  logic overflow_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  overflow_q <= 1'b0;
    else if (store_en && !push) overflow_q <= 1'b1;
  end
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_core_result_packer.sv
// Directed plus randomized bench for core_result_packer; a queue-based model predicts every beat.
module tb_core_result_packer;

  localparam int DIM   = 1023;
  localparam int OUT_W = 64;
  localparam int DEPTH = 4;
  localparam int BEATS = (DIM + 1) / OUT_W;
`ifdef PACKER_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, run, store, last, put_ready;
  logic [DIM:0]     core_result;
  logic             put_v, put_last, overflow;
  logic [OUT_W-1:0] put_d;

  core_result_packer #(.DIM(DIM), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .store      (store),
    .core_result(core_result),
    .last       (last),
    .put_v      (put_v),
    .put_d      (put_d),
    .put_last   (put_last),
    .put_ready  (put_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queue of whole vectors plus job-level flags
  logic [DIM:0]     vq[$];
  int               beat_idx = 0;
  bit               pend = 0, flush = 0, ovf = 0, m_hold = 0;
  bit               prev_stall = 0;
  logic [OUT_W-1:0] prev_d = '0;
  logic             prev_last = 1'b0;
  int               beats_seen = 0, lasts_seen = 0;

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] ex);
    n_assert++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic ex);
    n_assert++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, ex);
    end
  endtask

  function automatic logic [DIM:0] rand_vec();
    logic [DIM:0] v;
    for (int i = 0; i < (DIM + 1) / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic model_clear(input bit with_ovf);
    vq.delete();
    beat_idx   = 0;
    pend       = 0;
    flush      = 0;
    m_hold     = 0;
    prev_stall = 0;
    if (with_ovf) ovf = 0;
  endtask

  task automatic monitor();
    bit hs, pop, push, ex_last;
    logic [OUT_W-1:0] ex_d;
    logic [DIM:0] h;
    chk1("overflow", overflow, OvfEn & ovf);
    if (!run) begin
      model_clear(1'b0);
      return;
    end
    if (prev_stall) begin
      chk1("stall_v", put_v, 1'b1);
      chk("stall_d", put_d, prev_d);
      chk1("stall_last", put_last, prev_last);
    end
    hs   = put_v && put_ready;
    pop  = hs && !flush && (vq.size() > 0) && (beat_idx == BEATS - 1);
    push = store && ((vq.size() < DEPTH) || pop);
    ex_last = 1'b0;
    if (!flush && vq.size() > 0) begin
      if (prev_stall) ex_last = m_hold;
      else ex_last = (beat_idx == BEATS - 1) && (vq.size() == 1) && !push && pend;
      m_hold = ex_last;
    end
    if (hs) begin
      beats_seen++;
      if (put_last) lasts_seen++;
      if (flush) begin
        chk("flush_d", put_d, '0);
        chk1("flush_last", put_last, 1'b1);
        flush = 0;
        pend  = 0;
      end else if (vq.size() > 0) begin
        h    = vq[0];
        ex_d = h[beat_idx*OUT_W +: OUT_W];
        chk("beat_d", put_d, ex_d);
        chk1("beat_last", put_last, ex_last);
        if (ex_last) pend = 0;
        if (pop) begin
          void'(vq.pop_front());
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end else begin
        chk1("spurious_beat", put_v, 1'b0);
      end
    end
    prev_stall = put_v && !put_ready;
    prev_d     = put_d;
    prev_last  = put_last;
    if (push) vq.push_back(core_result);
    else if (store) ovf = 1;
    if (pop && vq.size() == 0 && pend) flush = 1;
    if (last) begin
      if (vq.size() == 0) flush = 1;
      else pend = 1;
    end
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic advance();
    monitor();
    @(posedge clk);
    #1;
    store = 1'b0;
    last  = 1'b0;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lbase;
    rst = 1'b1; run = 1'b0; store = 1'b0; last = 1'b0; put_ready = 1'b0; core_result = '0;
    #2;
    chk1("rst_put_v", put_v, 1'b0);
    chk("rst_put_d", put_d, '0);
    chk1("rst_put_last", put_last, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; run = 1'b1;
    tick();

    // Single vector, slice k carries k, last three cycles after store
    for (int k = 0; k < BEATS; k++) core_result[k*OUT_W +: OUT_W] = OUT_W'(k);
    put_ready = 1'b1;
    base = beats_seen; lbase = lasts_seen;
    store = 1'b1;
    tick();
    for (int i = 0; i < BEATS; i++) begin
      last = (i == 2);
      settle();
      chk1("t1_valid", put_v, 1'b1);
      advance();
    end
    settle();
    chk1("t1_idle", put_v, 1'b0);
    advance();
    repeat (5) tick();
    chk("t1_beats", OUT_W'(beats_seen - base), OUT_W'(BEATS));
    chk("t1_lasts", OUT_W'(lasts_seen - lbase), OUT_W'(1));

    // Late last produces a separate zero flush beat
    base = beats_seen; lbase = lasts_seen;
    core_result = rand_vec(); store = 1'b1;
    tick();
    repeat (39) tick();
    last = 1'b1;
    tick();
    settle();
    chk1("t2_flush_v", put_v, 1'b1);
    chk("t2_flush_d", put_d, '0);
    chk1("t2_flush_last", put_last, 1'b1);
    advance();
    repeat (3) tick();
    chk("t2_beats", OUT_W'(beats_seen - base), OUT_W'(BEATS + 1));
    chk("t2_lasts", OUT_W'(lasts_seen - lbase), OUT_W'(1));

    // Backpressure 1,0,0,1 over two queued vectors
    base = beats_seen; lbase = lasts_seen;
    for (int c = 0; c < 120; c++) begin
      put_ready = (c % 4 == 0) || (c % 4 == 3);
      if (c < 2) begin
        core_result = rand_vec();
        store = 1'b1;
        last  = (c == 1);
      end
      tick();
    end
    put_ready = 1'b1;
    tick();
    chk("t3_beats", OUT_W'(beats_seen - base), OUT_W'(2 * BEATS));
    chk("t3_lasts", OUT_W'(lasts_seen - lbase), OUT_W'(1));

    // Overflow: six stores into a stalled FIFO
    base = beats_seen; lbase = lasts_seen;
    put_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      core_result = rand_vec(); store = 1'b1;
      tick();
      if (i == 3) begin
        settle();
        chk1("t4_ovf_4", overflow, 1'b0);
        advance();
      end
      if (i == 4) begin
        settle();
        chk1("t4_ovf_5", overflow, OvfEn);
        advance();
      end
    end
    put_ready = 1'b1; last = 1'b1;
    tick();
    repeat (80) tick();
    chk("t4_beats", OUT_W'(beats_seen - base), OUT_W'(DEPTH * BEATS));
    chk("t4_lasts", OUT_W'(lasts_seen - lbase), OUT_W'(1));
    run = 1'b0;
    tick();
    run = 1'b1;
    settle();
    chk1("t4_ovf_run", overflow, OvfEn);
    advance();
    rst = 1'b1;
    settle();
    chk1("t4_ovf_rst", overflow, 1'b0);
    model_clear(1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Abort at beat 7, then a fresh one-vector job
    put_ready = 1'b1;
    core_result = rand_vec(); store = 1'b1;
    tick();
    repeat (7) tick();
    run = 1'b0;
    tick();
    run = 1'b1;
    base = beats_seen; lbase = lasts_seen;
    core_result = rand_vec(); store = 1'b1; last = 1'b1;
    settle();
    chk1("t5_abort", put_v, 1'b0);
    advance();
    for (int i = 0; i < BEATS; i++) begin
      settle();
      chk1("t5_valid", put_v, 1'b1);
      advance();
    end
    repeat (3) tick();
    chk("t5_beats", OUT_W'(beats_seen - base), OUT_W'(BEATS));
    chk("t5_lasts", OUT_W'(lasts_seen - lbase), OUT_W'(1));

    // Asynchronous reset between clock edges
    put_ready = 1'b0;
    core_result = rand_vec(); store = 1'b1;
    tick();
    tick();
    settle();
    chk1("t6_pre_v", put_v, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk1("t6_put_v", put_v, 1'b0);
    chk("t6_put_d", put_d, '0);
    chk1("t6_put_last", put_last, 1'b0);
    chk1("t6_overflow", overflow, 1'b0);
    model_clear(1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Randomized jobs with random backpressure
    for (int j = 0; j < 6; j++) begin
      int ns, w;
      bit sent_last;
      ns = $urandom_range(1, 6);
      sent_last = 0;
      for (int s = 0; s < ns; s++) begin
        int gap;
        gap = $urandom_range(0, 20);
        for (int g = 0; g < gap; g++) begin
          put_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        put_ready = ($urandom_range(0, 3) != 0);
        core_result = rand_vec(); store = 1'b1;
        if (s == ns - 1 && $urandom_range(0, 1) == 1) begin
          last = 1'b1;
          sent_last = 1;
        end
        tick();
      end
      if (!sent_last) begin
        int lgap;
        lgap = $urandom_range(0, 30);
        for (int g = 0; g < lgap; g++) begin
          put_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        last = 1'b1;
        tick();
      end
      w = 0;
      while ((vq.size() > 0 || flush || put_v) && w < 400) begin
        put_ready = ($urandom_range(0, 3) != 0);
        tick();
        w++;
      end
      settle();
      chk1("t7_idle", put_v, 1'b0);
      chk("t7_pending", OUT_W'(vq.size() + int'(flush)), '0);
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
